// File: rtl/lbm_field_reader.sv
// Frame sweeper for the LBM macroscopic field memories: reads p/ux/uy for every cell and
// streams one registered {addr, p, ux, uy} record per valid/ready handshake.
module lbm_field_reader #(
  parameter int GRID_DIM        = 256,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = $clog2(GRID_DIM),
  parameter int FRACTIONAL_BITS = 24
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET,
  input  logic                     start,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    p_mem_data_out,
  input  logic [DATA_WIDTH-1:0]    ux_mem_data_out,
  input  logic [DATA_WIDTH-1:0]    uy_mem_data_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]    out_p,
  output logic [DATA_WIDTH-1:0]    out_ux,
  output logic [DATA_WIDTH-1:0]    out_uy,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              frame_count
);

  // Field words are fixed point and passed through untouched; only sanity-check the format.
  if (FRACTIONAL_BITS >= DATA_WIDTH) begin : g_frac_check
    $error("FRACTIONAL_BITS must be smaller than DATA_WIDTH");
  end

  localparam logic [ADDRESS_WIDTH-1:0] LastAddr = ADDRESS_WIDTH'(GRID_DIM - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                     inflight_q;
  logic [ADDRESS_WIDTH-1:0] inflight_addr_q;
  logic [ADDRESS_WIDTH-1:0] fifo_addr_q [2];
  logic [DATA_WIDTH-1:0]    fifo_p_q    [2];
  logic [DATA_WIDTH-1:0]    fifo_ux_q   [2];
  logic [DATA_WIDTH-1:0]    fifo_uy_q   [2];
  logic                     rd_ptr_q, wr_ptr_q;
  logic [1:0]               count_q;
  logic [15:0]              frame_count_q;
  logic                     push, pop;
  logic [2:0]               occupancy;

  always_comb begin
    out_valid = (count_q != 2'd0);
    pop       = out_valid && out_ready;
    push      = inflight_q;
    // Credit includes the slot freed by a pop this cycle, which sustains 1 record per cycle.
    occupancy = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
    out_addr  = fifo_addr_q[rd_ptr_q];
    out_p     = fifo_p_q[rd_ptr_q];
    out_ux    = fifo_ux_q[rd_ptr_q];
    out_uy    = fifo_uy_q[rd_ptr_q];
    out_last  = out_valid && (out_addr == LastAddr);
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRead;
          rd_addr_d = '0;
        end
      end
      StRead: begin
        busy = 1'b1;
        if (occupancy < 3'd2) begin
          rd_en = 1'b1;
          if (rd_addr_q == LastAddr) begin
            state_d = StDrain;
          end else begin
            rd_addr_d = rd_addr_q + ADDRESS_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (pop && out_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      state_q         <= StIdle;
      rd_addr_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      frame_count_q   <= 16'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_p_q[i]    <= '0;
        fifo_ux_q[i]   <= '0;
        fifo_uy_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= rd_en;
      if (rd_en) begin
        inflight_addr_q <= rd_addr_q;
      end
      if (push) begin
        fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
        fifo_p_q[wr_ptr_q]    <= p_mem_data_out;
        fifo_ux_q[wr_ptr_q]   <= ux_mem_data_out;
        fifo_uy_q[wr_ptr_q]   <= uy_mem_data_out;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      if (state_q == StDone) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign rd_addr     = rd_addr_q;
  assign frame_count = frame_count_q;

endmodule
